// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  dmem_responder : MEM-stage data-memory responder, direct-mapped write-back
//                   cache with one-word lines over a req/ack backing port.
//  Revision 1.0
// ============================================================================
module dmem_responder #(
    parameter int INDEX_BITS = 6
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MemRead_2DM,
    input  logic        MemWrite_2DM,
    input  logic        MemFlush_2DM,
    input  logic [31:0] data_address_2DM,
    input  logic [31:0] data_write_2DM,
    input  logic [1:0]  data_write_size_2DM,
    output logic [31:0] data_read_fDM,
    output logic        data_valid_fDM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 30 - INDEX_BITS;
    localparam logic [INDEX_BITS-1:0] LAST_IDX = '1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WB      = 3'd1,
        FILL    = 3'd2,
        FL_SCAN = 3'd3,
        FL_WB   = 3'd4,
        FL_DONE = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [31:0]           data_q [LINES];
    logic [TAG_W-1:0]      tag_q  [LINES];
    logic [LINES-1:0]      valid_q, valid_d, dirty_q, dirty_d;
    logic [INDEX_BITS-1:0] ptr_q, ptr_d;
    logic [31:2]           miss_addr_q, miss_addr_d;
    logic                  mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [31:0]           mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;

    logic [INDEX_BITS-1:0] idx, miss_idx, arr_idx;
    logic [TAG_W-1:0]      tag;
    logic                  hit, arr_we, tag_we;
    logic [31:0]           arr_wdata, merged;
    logic [2:0]            nbytes;
    logic [4:0]            shamt;

    assign idx      = data_address_2DM[INDEX_BITS+1:2];
    assign tag      = data_address_2DM[31:INDEX_BITS+2];
    assign miss_idx = miss_addr_q[INDEX_BITS+1:2];
    assign hit      = valid_q[idx] && (tag_q[idx] == tag);

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Big-endian merge: write data is right-justified, lands MSB-first from the
    // start byte, and bytes running past byte 3 are dropped.
    always_comb begin
        nbytes = (data_write_size_2DM == 2'd0) ? 3'd4 : {1'b0, data_write_size_2DM};
        merged = data_q[idx];
        shamt  = '0;
        for (int k = 0; k < 4; k++) begin
            if (k >= int'(data_address_2DM[1:0]) &&
                k < int'(data_address_2DM[1:0]) + int'(nbytes)) begin
                shamt = 5'((int'(nbytes) - 1 - k + int'(data_address_2DM[1:0])) * 8);
                merged[31-8*k -: 8] = 8'(data_write_2DM >> shamt);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        valid_d        = valid_q;
        dirty_d        = dirty_q;
        ptr_d          = ptr_q;
        miss_addr_d    = miss_addr_q;
        mem_req_d      = mem_req_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        data_valid_fDM = 1'b0;
        data_read_fDM  = data_q[idx];
        arr_we         = 1'b0;
        tag_we         = 1'b0;
        arr_idx        = idx;
        arr_wdata      = merged;

        case (state_q)
            IDLE: begin
                if (MemRead_2DM || MemWrite_2DM) begin
                    if (hit) begin
                        data_valid_fDM = 1'b1;
                        if (MemWrite_2DM) begin
                            arr_we       = 1'b1;
                            dirty_d[idx] = 1'b1;
                        end
                    end else begin
                        miss_addr_d = data_address_2DM[31:2];
                        state_d     = (valid_q[idx] && dirty_q[idx]) ? WB : FILL;
                    end
                end else if (MemFlush_2DM) begin
                    ptr_d   = '0;
                    state_d = FL_SCAN;
                end else begin
                    data_valid_fDM = 1'b1;
                end
            end
            WB: begin
                if (!mem_req_q) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {tag_q[miss_idx], miss_idx, 2'b00};
                    mem_wdata_d = data_q[miss_idx];
                end else if (mem_ack) begin
                    mem_req_d         = 1'b0;
                    dirty_d[miss_idx] = 1'b0;
                    state_d           = FILL;
                end
            end
            FILL: begin
                if (!mem_req_q) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {miss_addr_q, 2'b00};
                end else if (mem_ack) begin
                    mem_req_d         = 1'b0;
                    arr_we            = 1'b1;
                    tag_we            = 1'b1;
                    arr_idx           = miss_idx;
                    arr_wdata         = mem_rdata;
                    valid_d[miss_idx] = 1'b1;
                    dirty_d[miss_idx] = 1'b0;
                    state_d           = IDLE;
                end
            end
            FL_SCAN: begin
                if (valid_q[ptr_q] && dirty_q[ptr_q]) begin
                    state_d = FL_WB;
                end else if (ptr_q == LAST_IDX) begin
                    state_d = FL_DONE;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            FL_WB: begin
                if (!mem_req_q) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {tag_q[ptr_q], ptr_q, 2'b00};
                    mem_wdata_d = data_q[ptr_q];
                end else if (mem_ack) begin
                    mem_req_d      = 1'b0;
                    dirty_d[ptr_q] = 1'b0;
                    // Last line written back: skip the rescan that a wrapped pointer would start
                    if (ptr_q == LAST_IDX) begin
                        state_d = FL_DONE;
                    end else begin
                        ptr_d   = ptr_q + 1'b1;
                        state_d = FL_SCAN;
                    end
                end
            end
            FL_DONE: begin
                data_valid_fDM = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            ptr_q       <= '0;
            miss_addr_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            ptr_q       <= ptr_d;
            miss_addr_q <= miss_addr_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (arr_we) begin
            data_q[arr_idx] <= arr_wdata;
        end
        if (tag_we) begin
            tag_q[arr_idx] <= miss_addr_q[31:INDEX_BITS+2];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  tb_dmem_responder : scoreboard bench with a fixed-latency backing memory.
//  Revision 1.0
// ============================================================================
module tb_dmem_responder;
    localparam int INDEX_BITS = 6;
    localparam int LAT        = 3;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        MemRead_2DM = 1'b0, MemWrite_2DM = 1'b0, MemFlush_2DM = 1'b0;
    logic [31:0] data_address_2DM = '0, data_write_2DM = '0;
    logic [1:0]  data_write_size_2DM = '0;
    logic [31:0] data_read_fDM;
    logic        data_valid_fDM, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t        exp_q[$];
    txn_t        obs_q[$];
    int          n_vec = 0, n_err = 0;
    int          cyc = 0, last_ack_cyc = 0;
    logic [31:0] bmem [logic [31:0]];
    bit          busy = 1'b0;
    int          cnt = 0;
    txn_t        cur;

    dmem_responder #(.INDEX_BITS(INDEX_BITS)) dut (
        .CLK                 (CLK),
        .RESET               (RESET),
        .MemRead_2DM         (MemRead_2DM),
        .MemWrite_2DM        (MemWrite_2DM),
        .MemFlush_2DM        (MemFlush_2DM),
        .data_address_2DM    (data_address_2DM),
        .data_write_2DM      (data_write_2DM),
        .data_write_size_2DM (data_write_size_2DM),
        .data_read_fDM       (data_read_fDM),
        .data_valid_fDM      (data_valid_fDM),
        .mem_req             (mem_req),
        .mem_we              (mem_we),
        .mem_addr            (mem_addr),
        .mem_wdata           (mem_wdata),
        .mem_ack             (mem_ack),
        .mem_rdata           (mem_rdata)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'hDEAD_BEEF;
            32'h0000_0200: return 32'h1122_3344;
            default:       return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    function automatic txn_t mk(input logic we, input logic [31:0] a, input logic [31:0] d);
        mk.we = we; mk.addr = a; mk.wdata = d;
    endfunction

    // Backing memory: latches a request, acks LAT negedges later, ignores reset
    always @(negedge CLK) begin
        mem_ack = 1'b0;
        if (busy) begin
            if (cnt == 0) begin
                mem_ack      = 1'b1;
                busy         = 1'b0;
                last_ack_cyc = cyc;
                if (cur.we) bmem[cur.addr] = cur.wdata;
                else mem_rdata = bmem.exists(cur.addr) ? bmem[cur.addr] : init_word(cur.addr);
                obs_q.push_back(cur);
            end else begin
                cnt--;
            end
        end else if (mem_req) begin
            busy = 1'b1;
            cnt  = LAT - 1;
            cur  = mk(mem_we, mem_addr, mem_wdata);
        end
    end

    task automatic access(input logic wr, input logic rd, input logic fl, input logic [31:0] a,
                          input logic [31:0] wd, input logic [1:0] sz,
                          output int cycles, output logic [31:0] rdata, output int vcyc);
        @(posedge CLK); #1;
        MemWrite_2DM = wr; MemRead_2DM = rd; MemFlush_2DM = fl;
        data_address_2DM = a; data_write_2DM = wd; data_write_size_2DM = sz;
        cycles = 0;
        @(negedge CLK);
        while (!data_valid_fDM && cycles < 2000) begin
            cycles++;
            @(negedge CLK);
        end
        rdata = data_read_fDM;
        vcyc  = cyc;
        if (!data_valid_fDM) begin
            n_vec++; n_err++;
            $display("FAIL timeout: no data_valid_fDM for addr %h after %0d cycles", a, cycles);
        end
        @(posedge CLK); #1;
        MemWrite_2DM = 1'b0; MemRead_2DM = 1'b0; MemFlush_2DM = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK);
        #1 RESET = 1'b1;
        @(negedge CLK);
        n_vec++; if (mem_req !== 1'b0)   begin n_err++; $display("FAIL rst_req: got %b want 0", mem_req); end
        n_vec++; if (mem_we !== 1'b0)    begin n_err++; $display("FAIL rst_we: got %b want 0", mem_we); end
        n_vec++; if (mem_addr !== '0)    begin n_err++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
        n_vec++; if (mem_wdata !== '0)   begin n_err++; $display("FAIL rst_wdata: got %h want 0", mem_wdata); end
        n_vec++; if (data_valid_fDM !== 1'b1) begin n_err++; $display("FAIL rst_valid: got %b want 1", data_valid_fDM); end
    endtask

    task automatic test_fill();
        int cy, vc; logic [31:0] rd; txn_t e, o;
        exp_q.push_back(mk(1'b0, 32'h100, 32'h0));
        access(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 2'd0, cy, rd, vc);
        n_vec++; if (cy == 0) begin n_err++; $display("FAIL fill_miss: got %0d stall cycles want >0", cy); end
        n_vec++; if (rd !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL fill_data: got %h want deadbeef", rd); end
        n_vec++; if (vc !== last_ack_cyc + 1) begin n_err++; $display("FAIL fill_latency: valid cyc %0d want %0d", vc, last_ack_cyc + 1); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); n_vec++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL fill_txn: none, want we=%b addr=%h", e.we, e.addr); end
            else begin
                o = obs_q.pop_front();
                if (o.we !== e.we || o.addr !== e.addr) begin n_err++; $display("FAIL fill_txn: got we=%b addr=%h want we=%b addr=%h", o.we, o.addr, e.we, e.addr); end
            end
        end
        access(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 2'd0, cy, rd, vc);
        n_vec++; if (cy != 0) begin n_err++; $display("FAIL hit_latency: got %0d stall cycles want 0", cy); end
        n_vec++; if (rd !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL hit_data: got %h want deadbeef", rd); end
        n_vec++; if (obs_q.size() != 0) begin n_err++; $display("FAIL hit_no_req: got %0d backing txns want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_write_merge();
        int cy, vc; logic [31:0] rd; txn_t e, o;
        logic [31:0] wa [3]  = '{32'h201, 32'h202, 32'h203};
        logic [31:0] wd [3]  = '{32'hAB, 32'hCDEF, 32'h778899};
        logic [1:0]  ws [3]  = '{2'd1, 2'd2, 2'd3};
        logic [31:0] exw [3] = '{32'h11AB_3344, 32'h11AB_CDEF, 32'h11AB_CD77};
        exp_q.push_back(mk(1'b0, 32'h200, 32'h0));
        access(1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 2'd0, cy, rd, vc);
        n_vec++; if (rd !== 32'h1122_3344) begin n_err++; $display("FAIL merge_base: got %h want 11223344", rd); end
        for (int i = 0; i < 3; i++) begin
            access(1'b1, 1'b0, 1'b0, wa[i], wd[i], ws[i], cy, rd, vc);
            n_vec++; if (cy != 0) begin n_err++; $display("FAIL merge_wr_hit%0d: got %0d stall cycles want 0", i, cy); end
            access(1'b0, 1'b1, 1'b0, wa[i], 32'h0, 2'd0, cy, rd, vc);
            n_vec++; if (rd !== exw[i]) begin n_err++; $display("FAIL merge%0d: got %h want %h", i, rd, exw[i]); end
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); n_vec++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL merge_txn: none, want we=%b addr=%h", e.we, e.addr); end
            else begin
                o = obs_q.pop_front();
                if (o.we !== e.we || o.addr !== e.addr) begin n_err++; $display("FAIL merge_txn: got we=%b addr=%h want we=%b addr=%h", o.we, o.addr, e.we, e.addr); end
            end
        end
        n_vec++; if (obs_q.size() != 0) begin n_err++; $display("FAIL merge_extra: got %0d extra txns want 0", obs_q.size()); obs_q.delete(); end
    endtask

    // 0x000, 0x100, 0x200, 0x300 all map to index 0 with INDEX_BITS=6
    task automatic test_dirty_evict();
        int cy, vc; logic [31:0] rd; txn_t e, o;
        exp_q.push_back(mk(1'b1, 32'h200, 32'h11AB_CD77));
        exp_q.push_back(mk(1'b0, 32'h000, 32'h0));
        access(1'b1, 1'b0, 1'b0, 32'h000, 32'hCAFE_F00D, 2'd0, cy, rd, vc);
        exp_q.push_back(mk(1'b1, 32'h000, 32'hCAFE_F00D));
        exp_q.push_back(mk(1'b0, 32'h000 + (32'd4 << INDEX_BITS), 32'h0));
        access(1'b0, 1'b1, 1'b0, 32'h000 + (32'd4 << INDEX_BITS), 32'h0, 2'd0, cy, rd, vc);
        n_vec++; if (rd !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL evict_data: got %h want deadbeef", rd); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); n_vec++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL evict_txn: none, want we=%b addr=%h", e.we, e.addr); end
            else begin
                o = obs_q.pop_front();
                if (o.we !== e.we || o.addr !== e.addr || (e.we && o.wdata !== e.wdata)) begin
                    n_err++; $display("FAIL evict_txn: got we=%b addr=%h d=%h want we=%b addr=%h d=%h", o.we, o.addr, o.wdata, e.we, e.addr, e.wdata);
                end
            end
        end
    endtask

    task automatic test_flush();
        int cy, vc; logic [31:0] rd; txn_t e, o;
        access(1'b1, 1'b0, 1'b0, 32'h004, 32'h0101_0101, 2'd0, cy, rd, vc);
        access(1'b1, 1'b0, 1'b0, 32'h014, 32'h0505_0505, 2'd0, cy, rd, vc);
        obs_q.delete();
        exp_q.push_back(mk(1'b1, 32'h004, 32'h0101_0101));
        exp_q.push_back(mk(1'b1, 32'h014, 32'h0505_0505));
        access(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 2'd0, cy, rd, vc);
        n_vec++; if (cy < (1 << INDEX_BITS)) begin n_err++; $display("FAIL flush_len: got %0d stall cycles want >=%0d", cy, 1 << INDEX_BITS); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); n_vec++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL flush_txn: none, want addr=%h", e.addr); end
            else begin
                o = obs_q.pop_front();
                if (o.we !== e.we || o.addr !== e.addr || o.wdata !== e.wdata) begin
                    n_err++; $display("FAIL flush_txn: got we=%b addr=%h d=%h want we=%b addr=%h d=%h", o.we, o.addr, o.wdata, e.we, e.addr, e.wdata);
                end
            end
        end
        n_vec++; if (obs_q.size() != 0) begin n_err++; $display("FAIL flush_extra: got %0d extra txns want 0", obs_q.size()); obs_q.delete(); end
        access(1'b0, 1'b1, 1'b0, 32'h004, 32'h0, 2'd0, cy, rd, vc);
        n_vec++; if (cy != 0 || rd !== 32'h0101_0101) begin n_err++; $display("FAIL flush_hit1: got %0d cycles data %h want 0 cycles 01010101", cy, rd); end
        access(1'b0, 1'b1, 1'b0, 32'h014, 32'h0, 2'd0, cy, rd, vc);
        n_vec++; if (cy != 0 || rd !== 32'h0505_0505) begin n_err++; $display("FAIL flush_hit5: got %0d cycles data %h want 0 cycles 05050505", cy, rd); end
        n_vec++; if (obs_q.size() != 0) begin n_err++; $display("FAIL flush_clean: got %0d txns after flush want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_reset_mid_fill();
        int n, cy, vc; logic [31:0] rd; txn_t o;
        @(posedge CLK); #1;
        MemRead_2DM = 1'b1; data_address_2DM = 32'h300;
        n = 0;
        @(negedge CLK);
        while (!mem_req && n < 20) begin n++; @(negedge CLK); end
        #1 RESET = 1'b0;
        #1;
        n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rstfill_req: got %b want 0", mem_req); end
        n_vec++; if (mem_addr !== '0) begin n_err++; $display("FAIL rstfill_addr: got %h want 0", mem_addr); end
        MemRead_2DM = 1'b0;
        @(negedge CLK); #1 RESET = 1'b1;
        n = 0;
        while (busy && n < 20) begin @(negedge CLK); n++; end
        @(negedge CLK);
        n_vec++; if (mem_req !== 1'b0 || data_valid_fDM !== 1'b1) begin n_err++; $display("FAIL late_ack: got req=%b valid=%b want req=0 valid=1", mem_req, data_valid_fDM); end
        n_vec++; if (obs_q.size() != 1) begin n_err++; $display("FAIL abandoned_txn: got %0d txns want 1", obs_q.size()); end
        obs_q.delete();
        access(1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 2'd0, cy, rd, vc);
        n_vec++; if (cy == 0) begin n_err++; $display("FAIL rstfill_miss: got %0d stall cycles want >0", cy); end
        n_vec++; if (rd !== 32'h5A5A_0300) begin n_err++; $display("FAIL rstfill_data: got %h want 5a5a0300", rd); end
        n_vec++;
        if (obs_q.size() != 1) begin n_err++; $display("FAIL rstfill_txn: got %0d txns want 1", obs_q.size()); obs_q.delete(); end
        else begin
            o = obs_q.pop_front();
            if (o.we !== 1'b0 || o.addr !== 32'h300) begin n_err++; $display("FAIL rstfill_txn: got we=%b addr=%h want we=0 addr=00000300", o.we, o.addr); end
        end
    endtask

    task automatic test_rw_both();
        int cy, vc; logic [31:0] rd; txn_t e, o;
        access(1'b1, 1'b1, 1'b0, 32'h300, 32'h55, 2'd1, cy, rd, vc);
        n_vec++; if (cy != 0) begin n_err++; $display("FAIL rw_hit: got %0d stall cycles want 0", cy); end
        exp_q.push_back(mk(1'b1, 32'h300, 32'h555A_0300));
        exp_q.push_back(mk(1'b0, 32'h000, 32'h0));
        access(1'b0, 1'b1, 1'b0, 32'h000, 32'h0, 2'd0, cy, rd, vc);
        n_vec++; if (rd !== 32'hCAFE_F00D) begin n_err++; $display("FAIL rw_refill: got %h want cafef00d", rd); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); n_vec++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL rw_txn: none, want we=%b addr=%h", e.we, e.addr); end
            else begin
                o = obs_q.pop_front();
                if (o.we !== e.we || o.addr !== e.addr || (e.we && o.wdata !== e.wdata)) begin
                    n_err++; $display("FAIL rw_txn: got we=%b addr=%h d=%h want we=%b addr=%h d=%h", o.we, o.addr, o.wdata, e.we, e.addr, e.wdata);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_write_merge();
        test_dirty_evict();
        test_flush();
        test_reset_mid_fill();
        test_rw_both();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Responder end of the MEM-stage data-memory interface: accepts read, write and flush requests from the MEM stage and returns aligned read words with a valid/stall handshake. Implemented as a direct-mapped, write-back, write-allocate data cache with one-word lines, backed by a multi-cycle req/ack memory port. The MEM stage performs all load alignment and extension; this block reads and writes raw big-endian words and bytes.

## Interface

- INDEX_BITS, 6, cache index width; 2^INDEX_BITS lines; tag = addr[31:INDEX_BITS+2]
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- MemRead_2DM  in  1  read request
- MemWrite_2DM  in  1  write request; wins if both read and write are high
- MemFlush_2DM  in  1  flush request: write back every dirty line
- data_address_2DM  in  32  byte address; index = [INDEX_BITS+1:2]
- data_write_2DM  in  32  write data, right-justified (low bytes used)
- data_write_size_2DM  in  2  bytes to write: 0=4, 1=1, 2=2, 3=3
- data_read_fDM  out  32  full word at {addr[31:2],2'b00}
- data_valid_fDM  out  1  request complete this cycle; requester stalls while low
- mem_req  out  1  backing request, held until mem_ack
- mem_we  out  1  backing write (1) / read (0)
- mem_addr  out  32  word-aligned backing address
- mem_wdata  out  32  backing write data
- mem_ack  in  1  one-cycle backing completion pulse
- mem_rdata  in  32  backing read data, valid with mem_ack

## Operation

- States: IDLE, WB, FILL, FL_SCAN, FL_WB, FL_DONE.
- IDLE, no request: data_valid_fDM=1, data_read_fDM = array word at index (don't care).
- IDLE, read/write hit (valid && tag match): data_valid_fDM=1 combinationally; read returns stored word; write merges at the clock edge and sets dirty.
- Write merge, big-endian: byte k = bits [31-8k -: 8]. n = size (0 means 4) bytes, start byte b = addr[1:0]; data_write_2DM[8n-1:0] lands on bytes b..b+n-1, most significant first; bytes past byte 3 are dropped (no wrap). Untouched bytes keep their value.
- IDLE, miss: data_valid_fDM=0; victim dirty -> WB, else -> FILL.
- WB: mem_req=1, mem_we=1, mem_addr={victim tag,index,2'b00}, mem_wdata=victim word; on mem_ack clear dirty -> FILL.
- FILL: mem_req=1, mem_we=0, mem_addr={addr[31:2],2'b00}; on mem_ack install word, tag, valid=1, dirty=0 -> IDLE; the request then hits.
- Flush in IDLE: data_valid_fDM=0 -> FL_SCAN with scan pointer 0. FL_SCAN: if line[ptr] valid && dirty -> FL_WB, else ptr+1; after the last index -> FL_DONE. FL_WB writes back like WB, clears dirty, ptr+1 -> FL_SCAN. Lines stay valid.
- FL_DONE: data_valid_fDM=1 for exactly one cycle -> IDLE.
- Requester holds request signals stable until data_valid_fDM. If the request drops mid-miss, the transaction still completes and the line is installed.

## Timing

- Hit: 0-cycle latency; valid in the same cycle as the request.
- Clean miss: FILL entry + ack wait + 1 IDLE cycle; valid arrives mem_ack-cycle + 1.
- Dirty miss: adds one WB transaction before FILL.
- Flush: 2^INDEX_BITS scan cycles + one WB transaction per dirty line + 1 FL_DONE cycle.
- Backing port: mem_req, mem_we, mem_addr and mem_wdata are registered and stable from assertion until the ack cycle; mem_req drops the cycle after mem_ack. No second request is issued in the ack cycle.
- Reset (async, any state): state=IDLE; all valid/dirty bits=0; scan ptr=0; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0. An in-flight backing transaction is abandoned and its late ack is ignored. Data array contents are undefined.

## Test plan

- Read 0x100 after reset: fill via backing (mem_rdata=0xDEADBEEF, ack 3 cycles later) -> data_read_fDM=0xDEADBEEF with valid at ack+1; second read of 0x100 -> valid same cycle, no mem_req.
- Word 0x11223344 at 0x200: SB at 0x201 with data 0xAB -> 0x11AB3344; SH at 0x202 with data 0xCDEF -> 0x11ABCDEF; size 3 at 0x203 with data 0x778899 -> 0x11ABCD77.
- Dirty line at 0x000, then read 0x000 + (4<<INDEX_BITS): WB of the old word to 0x000, then FILL of the new address, then valid.
- Dirty lines at indices 1 and 5, then flush: exactly two backing writes in index order, FL_DONE valid for 1 cycle; a subsequent read of those lines hits with no WB.
- RESET asserted mid-FILL: mem_req=0 immediately; a late mem_ack is ignored; the next read of the same address misses.
- Read and write both high on a hit: treated as a write, dirty set; a later eviction writes back the merged word.
